// File: rtl/mux_key_if.sv
// Bundle of the key-indexed mux signals: select key, packed table, fallback
// value and capture enable in; combinational and registered result out.
// The master modport belongs to whoever owns the table, the slave to the mux.
interface mux_key_if #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
);
  logic [KEY_LEN-1:0]                   key;
  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut;
  logic [DATA_LEN-1:0]                  default_out;
  logic                                 en;
  logic [DATA_LEN-1:0]                  out;
  logic                                 hit;
  logic [DATA_LEN-1:0]                  out_q;
  logic                                 hit_q;

  modport master (
    output key, lut, default_out, en,
    input  out, hit, out_q, hit_q
  );

  modport slave (
    input  key, lut, default_out, en,
    output out, hit, out_q, hit_q
  );
endinterface

// File: rtl/mux_key.sv
// Key-indexed mux: picks the data of the lowest-index table entry whose key matches.
// Latency: out/hit are combinational; out_q/hit_q follow one clock later when en=1.
// No backpressure: en only gates capture into the output registers.
module mux_key #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input logic      clk,
  input logic      rst,
  mux_key_if.slave bus
);
  localparam int ENTRY_LEN = KEY_LEN + DATA_LEN;

  // Table unpacked into per-entry key/data; entry 0 sits in the top slice.
  logic [KEY_LEN-1:0]  tbl_key  [NR_KEY];
  logic [DATA_LEN-1:0] tbl_data [NR_KEY];

  for (genvar g = 0; g < NR_KEY; g++) begin : g_entry
    localparam int BASE = (NR_KEY - 1 - g) * ENTRY_LEN;
    assign tbl_key[g]  = bus.lut[BASE + ENTRY_LEN - 1 -: KEY_LEN];
    assign tbl_data[g] = bus.lut[BASE + DATA_LEN - 1 -: DATA_LEN];
  end

  logic [NR_KEY-1:0]   match;
  logic [DATA_LEN-1:0] sel;

  // Compare every entry; walk from the highest index down so the lowest match overrides.
  always_comb begin
    match = '0;
    sel   = bus.default_out;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (tbl_key[i] == bus.key) begin
        match[i] = 1'b1;
        sel      = tbl_data[i];
      end
    end
  end

  assign bus.out = sel;
  assign bus.hit = |match;

  logic [DATA_LEN-1:0] out_r;
  logic                hit_r;

  // Capture the combinational result when enabled; reset clears it immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= '0;
      hit_r <= 1'b0;
    end else if (bus.en) begin
      out_r <= sel;
      hit_r <= |match;
    end
  end

  assign bus.out_q = out_r;
  assign bus.hit_q = hit_r;
endmodule

// File: tb/tb_mux_key.sv
// Bench for mux_key: three instances (width-mask, sparse wide-data, random 8-entry).
// Stimulus queues expected values; a negedge monitor pops and compares them.
// The random instance is checked against a first-match search over plain arrays.
module tb_mux_key;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mux_key_if #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8))  if_a ();
  mux_key_if #(.NR_KEY(2), .KEY_LEN(3), .DATA_LEN(64)) if_b ();
  mux_key_if #(.NR_KEY(8), .KEY_LEN(3), .DATA_LEN(16)) if_c ();

  mux_key #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8))  dut_a (.clk(clk), .rst(rst), .bus(if_a));
  mux_key #(.NR_KEY(2), .KEY_LEN(3), .DATA_LEN(64)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  mux_key #(.NR_KEY(8), .KEY_LEN(3), .DATA_LEN(16)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  // Signal selectors: instance * 4 + field (0 out, 1 hit, 2 out_q, 3 hit_q).
  localparam int A = 0;
  localparam int B = 4;
  localparam int C = 8;
  localparam int OUT = 0, HIT = 1, OUTQ = 2, HITQ = 3;

  typedef struct {
    string       name;
    int          sig;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] actual(int sig);
    case (sig)
      A + OUT:  return 64'(if_a.out);
      A + HIT:  return 64'(if_a.hit);
      A + OUTQ: return 64'(if_a.out_q);
      A + HITQ: return 64'(if_a.hit_q);
      B + OUT:  return if_b.out;
      B + HIT:  return 64'(if_b.hit);
      B + OUTQ: return if_b.out_q;
      B + HITQ: return 64'(if_b.hit_q);
      C + OUT:  return 64'(if_c.out);
      C + HIT:  return 64'(if_c.hit);
      C + OUTQ: return 64'(if_c.out_q);
      C + HITQ: return 64'(if_c.hit_q);
      default:  return 64'hx;
    endcase
  endfunction

  task automatic expect_val(string name, int sig, logic [63:0] v);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // Monitor: compare every queued expectation against what the DUT shows mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [63:0] act;
      e   = sb.pop_front();
      act = actual(e.sig);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: first entry (lowest index) whose key equals k wins; else default.
  function automatic void ref_search(input logic [2:0] keys[8], input logic [15:0] data[8],
                                     input logic [2:0] k, input logic [15:0] dflt,
                                     output logic [15:0] o, output logic h);
    o = dflt;
    h = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!h && keys[i] == k) begin
        h = 1'b1;
        o = data[i];
      end
    end
  endfunction

  logic [7:0]   wm [4] = '{8'h01, 8'h03, 8'h0f, 8'hff};
  logic [2:0]   rkeys [8];
  logic [15:0]  rdata [8];
  logic [151:0] rlut;
  logic [15:0]  rdflt, ref_o, prev_o, q_o;
  logic [2:0]   rkey;
  logic         ref_h, prev_h, q_h, en_prev;

  initial begin
    if_a.key = 2'b10;
    if_a.lut = {2'b00, 8'h01, 2'b01, 8'h03, 2'b10, 8'h0f, 2'b11, 8'hff};
    if_a.default_out = 8'h00;
    if_a.en = 1'b0;
    if_b.key = 3'b000;
    if_b.lut = {3'b000, 64'h1111_2222, 3'b100, 64'h3333_4444};
    if_b.default_out = 64'hDEAD;
    if_b.en = 1'b0;
    if_c.key = 3'b000;
    if_c.lut = '0;
    if_c.default_out = '0;
    if_c.en = 1'b0;

    // Reset state; combinational path stays live during reset.
    step();
    expect_val("rst_out_q", A + OUTQ, 64'h0);
    expect_val("rst_hit_q", A + HITQ, 64'h0);
    expect_val("rst_b_out_q", B + OUTQ, 64'h0);
    expect_val("out_in_rst", A + OUT, 64'h0f);
    step();
    rst = 1'b0;

    // Width-mask sweep.
    for (int k = 0; k < 4; k++) begin
      step();
      if_a.key = 2'(k);
      expect_val($sformatf("wm_out_k%0d", k), A + OUT, 64'(wm[k]));
      expect_val($sformatf("wm_hit_k%0d", k), A + HIT, 64'h1);
    end

    // Sparse wide table.
    step();
    if_b.key = 3'b100;
    expect_val("sparse_out_100", B + OUT, 64'h3333_4444);
    expect_val("sparse_hit_100", B + HIT, 64'h1);
    step();
    if_b.key = 3'b010;
    expect_val("sparse_out_010", B + OUT, 64'hDEAD);
    expect_val("sparse_hit_010", B + HIT, 64'h0);
    step();
    if_b.key = 3'b000;
    expect_val("sparse_out_000", B + OUT, 64'h1111_2222);

    // Registered path: capture, then hold with en low.
    step();
    if_a.key = 2'b10;
    if_a.en  = 1'b1;
    step();
    expect_val("cap_out_q", A + OUTQ, 64'h0f);
    expect_val("cap_hit_q", A + HITQ, 64'h1);
    if_a.en  = 1'b0;
    if_a.key = 2'b11;
    expect_val("hold_out", A + OUT, 64'hff);
    step();
    expect_val("hold_out_q1", A + OUTQ, 64'h0f);
    step();
    expect_val("hold_out_q2", A + OUTQ, 64'h0f);

    // Asynchronous reset mid-cycle, then reset beats enable.
    step();
    #2;
    rst = 1'b1;
    expect_val("async_out_q", A + OUTQ, 64'h0);
    expect_val("async_hit_q", A + HITQ, 64'h0);
    if_a.en = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      expect_val($sformatf("rstpri_out_q%0d", n), A + OUTQ, 64'h0);
      expect_val($sformatf("rstpri_hit_q%0d", n), A + HITQ, 64'h0);
    end
    rst = 1'b0;
    step();
    expect_val("post_rst_out_q", A + OUTQ, 64'hff);
    expect_val("post_rst_hit_q", A + HITQ, 64'h1);
    if_a.en = 1'b0;

    // Duplicate keys: lowest index visible, no OR of data.
    if_a.lut = {2'b01, 8'hAA, 2'b01, 8'h55, 2'b01, 8'h33, 2'b00, 8'h0F};
    if_a.key = 2'b01;
    expect_val("dup_out", A + OUT, 64'hAA);
    expect_val("dup_hit", A + HIT, 64'h1);
    step();
    if_a.key = 2'b11;
    if_a.default_out = 8'h5A;
    expect_val("miss_default", A + OUT, 64'h5A);
    expect_val("miss_hit", A + HIT, 64'h0);

    // Randomised equivalence on the 8-entry instance.
    q_o = '0; q_h = 1'b0; en_prev = 1'b0; prev_o = '0; prev_h = 1'b0;
    for (int it = 0; it < 1000; it++) begin
      step();
      if (en_prev) begin
        q_o = prev_o;
        q_h = prev_h;
      end
      expect_val($sformatf("rnd_out_q_%0d", it), C + OUTQ, 64'(q_o));
      expect_val($sformatf("rnd_hit_q_%0d", it), C + HITQ, 64'(q_h));
      rlut = '0;
      for (int i = 0; i < 8; i++) begin
        rkeys[i] = 3'($urandom_range(0, 7));
        rdata[i] = 16'($urandom);
        rlut = (rlut << 19) | 152'({rkeys[i], rdata[i]});
      end
      rkey  = 3'($urandom_range(0, 7));
      rdflt = 16'($urandom);
      if_c.lut = rlut;
      if_c.key = rkey;
      if_c.default_out = rdflt;
      if_c.en = ($urandom_range(0, 3) != 0);
      ref_search(rkeys, rdata, rkey, rdflt, ref_o, ref_h);
      expect_val($sformatf("rnd_out_%0d", it), C + OUT, 64'(ref_o));
      expect_val($sformatf("rnd_hit_%0d", it), C + HIT, 64'(ref_h));
      prev_o  = ref_o;
      prev_h  = ref_h;
      en_prev = if_c.en;
    end

    step();
    step();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
